// File: rtl/cr_lz77_comp_pkg.sv
// ---------------------------------------------------------------------------
// cr_lz77_comp_pkg
// Shared definitions for the LZ77 compressor select tree.
//   - STREE_LOG_N_MIN / STREE_LOG_N_MAX : supported range of LOG_N
//   - stree_stage_cnt()                 : number of register stages in the tree
// ---------------------------------------------------------------------------
package cr_lz77_comp_pkg;

  localparam int STREE_LOG_N_MIN = 1;
  localparam int STREE_LOG_N_MAX = 6;

  // A register bank closes every REG_EVERY levels, and the final level is
  // always registered, so a partial group at the top still costs one stage.
  function automatic int stree_stage_cnt(input int log_n, input int reg_every);
    return (log_n + reg_every - 1) / reg_every;
  endfunction

endpackage

// File: rtl/cr_lz77_comp_stree_node.sv
// ---------------------------------------------------------------------------
// cr_lz77_comp_stree_node
// Combinational binary select node of the longest-match tree.
// Ports:
//   i_thermA / i_thermB : thermometer of the lower / higher index branch
//   i_offA   / i_offB   : branch-local winner offsets (ignored when OI_WIDTH=0)
//   o_therm             : OR of both thermometers
//   o_off               : {branch select, winning branch offset}, OI_WIDTH+1 bits
// ---------------------------------------------------------------------------
module cr_lz77_comp_stree_node
  import cr_lz77_comp_pkg::*;
#(
  parameter  int T_WIDTH  = 8,
  parameter  int T_MASK   = 0,
  parameter  int OI_WIDTH = 0,
  localparam int OI_W     = (OI_WIDTH > 0) ? OI_WIDTH : 1
) (
  input  logic [T_WIDTH-1:0]  i_thermA,
  input  logic [T_WIDTH-1:0]  i_thermB,
  input  logic [OI_W-1:0]     i_offA,
  input  logic [OI_W-1:0]     i_offB,
  output logic [T_WIDTH-1:0]  o_therm,
  output logic [OI_WIDTH:0]   o_off
);

  localparam int M = T_WIDTH - T_MASK - 1;

  logic w_sel;

  // The higher branch wins only if it has a bit the lower branch lacks in
  // the compared (unmasked) range; equal lengths keep the lower index.
  assign w_sel   = |(~i_thermA[M:0] & i_thermB[M:0]);
  assign o_therm = i_thermA | i_thermB;

  // Leaf nodes have no incoming offsets: the select bit alone is the offset.
  generate
    if (OI_WIDTH == 0) begin : g_leaf
      logic w_unusedOff;
      assign w_unusedOff = ^{i_offA, i_offB};
      assign o_off       = w_sel;
    end else begin : g_inner
      assign o_off = {w_sel, w_sel ? i_offB : i_offA};
    end
  endgenerate

endmodule

// File: rtl/cr_lz77_comp_stree.sv
// ---------------------------------------------------------------------------
// cr_lz77_comp_stree
// Pipelined N_IN-input longest-match select tree with valid/ready flow
// control. Returns the winning candidate index and the OR of all inputs.
// Optional feature macro: CR_LZ77_STREE_LEN_OUT_EN adds o_out_len, the
// registered popcount of the final thermometer (no extra latency).
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   i_in_valid     : input beat valid
//   o_in_ready     : beat accepted this cycle (global pipe enable)
//   i_in_therm     : candidate i at [i*T_WIDTH +: T_WIDTH]
//   o_out_valid    : result valid
//   i_out_ready    : downstream accepts result
//   o_out_therm    : OR of all thermometers of the beat
//   o_out_offset   : index of the winning candidate
//   o_out_len      : popcount of o_out_therm (macro builds only)
// ---------------------------------------------------------------------------
module cr_lz77_comp_stree
  import cr_lz77_comp_pkg::*;
#(
  parameter  int LOG_N     = 3,
  parameter  int T_WIDTH   = 8,
  parameter  int T_MASK    = 0,
  parameter  int REG_EVERY = 1,
  localparam int N_IN      = 1 << LOG_N,
  localparam int LEN_W     = $clog2(T_WIDTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [N_IN*T_WIDTH-1:0]   i_in_therm,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
`ifdef CR_LZ77_STREE_LEN_OUT_EN
  output logic [LEN_W-1:0]          o_out_len,
`endif
  output logic [T_WIDTH-1:0]        o_out_therm,
  output logic [LOG_N-1:0]          o_out_offset
);

  localparam int S      = stree_stage_cnt(LOG_N, REG_EVERY);
  localparam int NODE_W = (N_IN / 2 > 0) ? N_IN / 2 : 1;

  logic [S-1:0]        r_stageValid;
  logic [S-1:0]        w_stageValidIn;
  logic                w_enable;
  logic [T_WIDTH-1:0]  w_lvlTherm [LOG_N][NODE_W];
  logic [LOG_N-1:0]    w_lvlOff   [LOG_N][NODE_W];

  // One global enable: the whole pipe advances whenever the output slot is
  // empty or being drained, so in_ready never looks at in_valid.
  assign w_enable    = !r_stageValid[S-1] || i_out_ready;
  assign o_in_ready  = w_enable;
  assign o_out_valid = r_stageValid[S-1];

  // Valid bit feeding each stage: the input for stage 0, else the previous stage.
  generate
    if (S == 1) begin : g_vin1
      assign w_stageValidIn = i_in_valid;
    end else begin : g_vinN
      assign w_stageValidIn = {r_stageValid[S-2:0], i_in_valid};
    end
  endgenerate

  // Valid chain shifts in lock step with the data banks; bubbles are kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stageValid <= '0;
    end else if (w_enable) begin
      r_stageValid <= w_stageValidIn;
    end
  end

`ifdef CR_LZ77_STREE_LEN_OUT_EN
  logic [T_WIDTH-1:0] w_finalTherm;
  logic [LEN_W-1:0]   r_outLen;

  function automatic logic [LEN_W-1:0] thermPopcount(input logic [T_WIDTH-1:0] v);
    logic [LEN_W-1:0] c;
    c = '0;
    for (int b = 0; b < T_WIDTH; b++) c = c + LEN_W'(v[b]);
    return c;
  endfunction

  // Popcount rides in the last register bank next to the final therm, so
  // it lines up with o_out_therm without adding a stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outLen <= '0;
    end else if (w_enable && w_stageValidIn[S-1]) begin
      r_outLen <= thermPopcount(w_finalTherm);
    end
  end

  assign o_out_len = r_outLen;
`endif

  // Tree levels: level l has N_IN>>(l+1) nodes and produces l+1 offset bits.
  // Slots beyond a level's node count are tied off so every array element
  // has a driver.
  generate
    for (genvar l = 0; l < LOG_N; l++) begin : g_lvl
      localparam int NODES = N_IN >> (l + 1);
      localparam int STG   = l / REG_EVERY;
      localparam bit IS_REG = (((l + 1) % REG_EVERY) == 0) || (l == LOG_N - 1);
      localparam int OFF_IN = (l > 0) ? l : 1;

      for (genvar j = 0; j < NODE_W; j++) begin : g_node
        if (j < NODES) begin : g_live
          logic [T_WIDTH-1:0] w_thermA, w_thermB, w_therm;
          logic [OFF_IN-1:0]  w_offA, w_offB;
          logic [l:0]         w_off;

          if (l == 0) begin : g_srcIn
            assign w_thermA = i_in_therm[(2*j)*T_WIDTH +: T_WIDTH];
            assign w_thermB = i_in_therm[(2*j+1)*T_WIDTH +: T_WIDTH];
            assign w_offA   = '0;
            assign w_offB   = '0;
          end else begin : g_srcLvl
            assign w_thermA = w_lvlTherm[l-1][2*j];
            assign w_thermB = w_lvlTherm[l-1][2*j+1];
            assign w_offA   = w_lvlOff[l-1][2*j][OFF_IN-1:0];
            assign w_offB   = w_lvlOff[l-1][2*j+1][OFF_IN-1:0];
          end

          cr_lz77_comp_stree_node #(
            .T_WIDTH  (T_WIDTH),
            .T_MASK   (T_MASK),
            .OI_WIDTH (l)
          ) u_node (
            .i_thermA (w_thermA),
            .i_thermB (w_thermB),
            .i_offA   (w_offA),
            .i_offB   (w_offB),
            .o_therm  (w_therm),
            .o_off    (w_off)
          );

`ifdef CR_LZ77_STREE_LEN_OUT_EN
          if (l == LOG_N - 1) begin : g_final
            assign w_finalTherm = w_therm;
          end
`endif

          if (IS_REG) begin : g_reg
            logic [T_WIDTH-1:0] r_therm;
            logic [l:0]         r_off;

            // Stage bank loads only for a valid upstream beat, so bubbles
            // leave the previous data in place.
            always_ff @(posedge clk or posedge rst) begin
              if (rst) begin
                r_therm <= '0;
                r_off   <= '0;
              end else if (w_enable && w_stageValidIn[STG]) begin
                r_therm <= w_therm;
                r_off   <= w_off;
              end
            end

            assign w_lvlTherm[l][j] = r_therm;
            assign w_lvlOff[l][j]   = LOG_N'(r_off);
          end else begin : g_comb
            assign w_lvlTherm[l][j] = w_therm;
            assign w_lvlOff[l][j]   = LOG_N'(w_off);
          end
        end else begin : g_dead
          assign w_lvlTherm[l][j] = '0;
          assign w_lvlOff[l][j]   = '0;
        end
      end
    end
  endgenerate

  assign o_out_therm  = w_lvlTherm[LOG_N-1][0];
  assign o_out_offset = w_lvlOff[LOG_N-1][0];

endmodule

// File: tb/tb_cr_lz77_comp_stree.sv
// ---------------------------------------------------------------------------
// tb_cr_lz77_comp_stree
// Drives two select trees with identical traffic: one unmasked and one with
// the two therm MSBs masked. Expected results come from a length-based model:
// the winner is the lowest index with the greatest (masked) thermometer length.
// ---------------------------------------------------------------------------
module tb_cr_lz77_comp_stree;

  parameter  int LOG_N     = 3;
  parameter  int REG_EVERY = 1;
  localparam int T_WIDTH   = 8;
  localparam int MASK_B    = 2;
  localparam int N_IN      = 1 << LOG_N;
  localparam int S_STAGES  = (LOG_N + REG_EVERY - 1) / REG_EVERY;
  localparam int LEN_W     = $clog2(T_WIDTH + 1);

  typedef struct {
    logic [T_WIDTH-1:0] therm;
    int                 offA;
    int                 offB;
    int                 len;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     inValid = 1'b0;
  logic [N_IN*T_WIDTH-1:0]  inTherm = '0;
  logic                     outReady = 1'b0;

  logic                     inReadyA, outValidA, inReadyB, outValidB;
  logic [T_WIDTH-1:0]       outThermA, outThermB;
  logic [LOG_N-1:0]         outOffA, outOffB;
`ifdef CR_LZ77_STREE_LEN_OUT_EN
  logic [LEN_W-1:0]         outLenA, outLenB;
`endif

  exp_t                     expQ[$];
  int                       curLens[N_IN];
  int                       testsRun = 0;
  int                       testsFailed = 0;
  int                       resultsSeen = 0;
  logic                     stallPrev = 1'b0;
  logic [T_WIDTH-1:0]       prevThermA, prevThermB;
  logic [LOG_N-1:0]         prevOffA, prevOffB;
  logic                     streamDone;

  cr_lz77_comp_stree #(
    .LOG_N(LOG_N), .T_WIDTH(T_WIDTH), .T_MASK(0), .REG_EVERY(REG_EVERY)
  ) u_dutA (
    .clk          (clk),
    .rst          (rst),
    .i_in_valid   (inValid),
    .o_in_ready   (inReadyA),
    .i_in_therm   (inTherm),
    .o_out_valid  (outValidA),
    .i_out_ready  (outReady),
`ifdef CR_LZ77_STREE_LEN_OUT_EN
    .o_out_len    (outLenA),
`endif
    .o_out_therm  (outThermA),
    .o_out_offset (outOffA)
  );

  cr_lz77_comp_stree #(
    .LOG_N(LOG_N), .T_WIDTH(T_WIDTH), .T_MASK(MASK_B), .REG_EVERY(REG_EVERY)
  ) u_dutB (
    .clk          (clk),
    .rst          (rst),
    .i_in_valid   (inValid),
    .o_in_ready   (inReadyB),
    .i_in_therm   (inTherm),
    .o_out_valid  (outValidB),
    .i_out_ready  (outReady),
`ifdef CR_LZ77_STREE_LEN_OUT_EN
    .o_out_len    (outLenB),
`endif
    .o_out_therm  (outThermB),
    .o_out_offset (outOffB)
  );

  always #5 clk = ~clk;

  // Hard stop in case something wedges the whole bench.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [T_WIDTH-1:0] thermOf(input int len);
    logic [T_WIDTH-1:0] t;
    t = '0;
    for (int b = 0; b < T_WIDTH; b++) if (b < len) t[b] = 1'b1;
    return t;
  endfunction

  // Reference: longest length wins, lowest index on ties; masking caps the
  // comparable length at T_WIDTH-mask but leaves the ORed thermometer alone.
  function automatic exp_t modelBeat(input int lens[N_IN]);
    exp_t e;
    int   bestA, bestB, capB, maxLen;
    bestA = -1; bestB = -1; maxLen = 0; capB = T_WIDTH - MASK_B;
    e.offA = 0; e.offB = 0;
    for (int i = 0; i < N_IN; i++) begin
      if (lens[i] > bestA) begin bestA = lens[i]; e.offA = i; end
      if ((lens[i] > capB ? capB : lens[i]) > bestB) begin
        bestB = (lens[i] > capB) ? capB : lens[i];
        e.offB = i;
      end
      if (lens[i] > maxLen) maxLen = lens[i];
    end
    e.therm = thermOf(maxLen);
    e.len   = maxLen;
    return e;
  endfunction

  // Cycle monitor on the falling edge: records accepted beats, scores
  // delivered results in order, and watches ready and stall stability.
  always @(negedge clk) begin
    if (rst) begin
      stallPrev = 1'b0;
    end else begin
      testsRun++;
      if (inReadyA !== (!outValidA || outReady)) begin
        testsFailed++;
        $display("[TB] FAIL readyA: got %b expected %b", inReadyA, !outValidA || outReady);
      end
      testsRun++;
      if (inReadyB !== (!outValidB || outReady)) begin
        testsFailed++;
        $display("[TB] FAIL readyB: got %b expected %b", inReadyB, !outValidB || outReady);
      end
      if (stallPrev) begin
        testsRun++;
        if ({outValidA, outThermA, outOffA, outValidB, outThermB, outOffB} !==
            {1'b1, prevThermA, prevOffA, 1'b1, prevThermB, prevOffB}) begin
          testsFailed++;
          $display("[TB] FAIL stall_hold: got %h/%h %h/%h expected %h/%h %h/%h",
                   outThermA, outOffA, outThermB, outOffB, prevThermA, prevOffA, prevThermB, prevOffB);
        end
      end
      if (inValid && inReadyA) expQ.push_back(modelBeat(curLens));
      if (outValidA && outReady) begin
        resultsSeen++;
        testsRun++;
        if (expQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL unexpected_result: got therm %h off %0d expected none", outThermA, outOffA);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          if (outThermA !== e.therm || outOffA !== LOG_N'(e.offA) || outValidB !== 1'b1 ||
              outThermB !== e.therm || outOffB !== LOG_N'(e.offB)) begin
            testsFailed++;
            $display("[TB] FAIL result: got A %h/%0d B %b %h/%0d expected A %h/%0d B 1 %h/%0d",
                     outThermA, outOffA, outValidB, outThermB, outOffB, e.therm, e.offA, e.therm, e.offB);
          end
`ifdef CR_LZ77_STREE_LEN_OUT_EN
          testsRun++;
          if (outLenA !== LEN_W'(e.len) || outLenB !== LEN_W'(e.len)) begin
            testsFailed++;
            $display("[TB] FAIL out_len: got %0d/%0d expected %0d", outLenA, outLenB, e.len);
          end
`endif
        end
      end
      stallPrev  = outValidA && !outReady;
      prevThermA = outThermA; prevOffA = outOffA;
      prevThermB = outThermB; prevOffB = outOffB;
    end
  end

  // Presents one beat and holds it until the pipe accepts it.
  task automatic applyStimulus(input int lens[N_IN]);
    logic accepted;
    int   waitCycles;
    for (int i = 0; i < N_IN; i++) begin
      curLens[i] = lens[i];
      inTherm[i*T_WIDTH +: T_WIDTH] = thermOf(lens[i]);
    end
    inValid    = 1'b1;
    waitCycles = 0;
    accepted   = 1'b0;
    while (!accepted && waitCycles < 200) begin
      @(negedge clk);
      accepted = inReadyA;
      @(posedge clk);
      #1;
      waitCycles++;
    end
    testsRun++;
    if (!accepted) begin
      testsFailed++;
      inValid = 1'b0;
      $display("[TB] FAIL accept_timeout: got no in_ready in %0d cycles expected accept", waitCycles);
    end
  endtask

  task automatic randomLens(output int lens[N_IN]);
    for (int i = 0; i < N_IN; i++) lens[i] = $urandom_range(0, T_WIDTH);
  endtask

  task automatic drainAll();
    int cycles;
    cycles = 0;
    while (expQ.size() != 0 && cycles < 500) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: got %0d results pending expected 0", expQ.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; inValid = 1'b0; outReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    testsRun++;
    if ({outValidA, outThermA, outOffA, outValidB, outThermB, outOffB} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got %b %h %h expected zeros", outValidA, outThermA, outOffA);
    end
`ifdef CR_LZ77_STREE_LEN_OUT_EN
    testsRun++;
    if (outLenA !== '0 || outLenB !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_len: got %0d expected 0", outLenA);
    end
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
    testsRun++;
    if (inReadyA !== 1'b1 || outValidA !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_ready: got ready %b valid %b expected 1 0", inReadyA, outValidA);
    end
  endtask

  task automatic test_single_latency();
    int lens[N_IN];
    int cycles;
    outReady = 1'b1;
    for (int i = 0; i < N_IN; i++) lens[i] = (i == 5) ? 6 : 4;
    applyStimulus(lens);
    inValid = 1'b0;
    cycles  = 1;
    @(negedge clk);
    while (!outValidA && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    testsRun++;
    if (cycles != S_STAGES) begin
      testsFailed++;
      $display("[TB] FAIL latency: got %0d cycles expected %0d", cycles, S_STAGES);
    end
    @(negedge clk);
    testsRun++;
    if (outValidA !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL single_pulse: got out_valid %b expected 0", outValidA);
    end
    drainAll();
  endtask

  task automatic test_tie_and_zero();
    int lens[N_IN];
    outReady = 1'b1;
    for (int i = 0; i < N_IN; i++) lens[i] = (i == 2 || i == 6) ? 8 : 1;
    applyStimulus(lens);
    for (int i = 0; i < N_IN; i++) lens[i] = 0;
    applyStimulus(lens);
    inValid = 1'b0;
    drainAll();
  endtask

  task automatic test_mask();
    int lens[N_IN];
    outReady = 1'b1;
    for (int i = 0; i < N_IN; i++) lens[i] = (i == 1) ? 8 : ((i == 0) ? 6 : 0);
    applyStimulus(lens);
    inValid = 1'b0;
    drainAll();
  endtask

  task automatic test_backpressure();
    int lens[N_IN];
    int seenBefore;
    seenBefore = resultsSeen;
    streamDone = 1'b0;
    fork
      begin
        for (int n = 0; n < 10; n++) begin
          randomLens(lens);
          applyStimulus(lens);
        end
        inValid    = 1'b0;
        streamDone = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!streamDone) begin
          outReady = (k % 4 == 0) || (k % 4 == 3);
          k++;
          @(posedge clk);
          #1;
        end
      end
    join
    outReady = 1'b1;
    drainAll();
    testsRun++;
    if (resultsSeen - seenBefore != 10) begin
      testsFailed++;
      $display("[TB] FAIL bp_count: got %0d results expected 10", resultsSeen - seenBefore);
    end
  endtask

  task automatic test_reset_midstream();
    int lens[N_IN];
    int seenBefore;
    outReady = 1'b0;
    for (int n = 0; n < S_STAGES; n++) begin
      randomLens(lens);
      applyStimulus(lens);
    end
    inValid = 1'b0;
    rst = 1'b1;
    #1;
    testsRun++;
    if ({outValidA, outThermA, outOffA, outValidB, outThermB, outOffB} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: got %b %h %h expected zeros", outValidA, outThermA, outOffA);
    end
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    testsRun++;
    if (inReadyA !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_ready: got %b expected 1", inReadyA);
    end
    outReady   = 1'b1;
    seenBefore = resultsSeen;
    repeat (2 * S_STAGES + 4) @(posedge clk);
    #1;
    testsRun++;
    if (resultsSeen != seenBefore) begin
      testsFailed++;
      $display("[TB] FAIL stale_result: got %0d results expected 0", resultsSeen - seenBefore);
    end
  endtask

  task automatic test_random();
    int lens[N_IN];
    streamDone = 1'b0;
    fork
      begin
        for (int n = 0; n < 150; n++) begin
          for (int i = 0; i < N_IN; i++)
            lens[i] = (n % 2 == 0) ? $urandom_range(5, 8) : $urandom_range(0, T_WIDTH);
          applyStimulus(lens);
          if ($urandom_range(0, 3) == 0) begin
            inValid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        inValid    = 1'b0;
        streamDone = 1'b1;
      end
      begin
        while (!streamDone) begin
          outReady = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    outReady = 1'b1;
    drainAll();
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_tie_and_zero();
    test_mask();
    test_backpressure();
    test_reset_midstream();
    test_random();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
